// File: rtl/sr_cmd_gen_pkg.sv
// ---------------------------------------------------------------------------
// sr_cmd_pkg
// Shared types for the SR command generator:
//   state_t : controller FSM states
//   cmd_t   : {s,r} command encoding driven onto the SR flip-flop
//   excite  : SR excitation table (desired Q + current Q -> {s,r})
// ---------------------------------------------------------------------------
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_CLR  = 2'b01,
        CMD_SET  = 2'b10
    } cmd_t;

    // Inverse of the SR characteristic table. While init is set the FF's
    // content is unknown, so the hold case is replaced by an explicit drive.
    function automatic cmd_t excite(input logic tgt, input logic q, input logic init);
        if (init || (tgt != q)) begin
            return tgt ? CMD_SET : CMD_CLR;
        end
        return CMD_HOLD;
    endfunction

endpackage

// File: rtl/sr_cmd_gen_if.sv
// ---------------------------------------------------------------------------
// sr_cmd_gen_if
// Request stream into the SR command generator.
//   req_valid : request present (controller -> generator)
//   req_ready : generator FIFO can accept a request (generator -> controller)
//   req_bit   : desired Q value (controller -> generator)
// Modports: master = controller side, slave = generator side.
// ---------------------------------------------------------------------------
interface sr_cmd_gen_if;

    logic req_valid;
    logic req_ready;
    logic req_bit;

    modport master (
        output req_valid,
        output req_bit,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_bit,
        output req_ready
    );

endinterface

// File: rtl/sr_cmd_gen_fifo.sv
// ---------------------------------------------------------------------------
// sr_cmd_fifo
// 1-bit wide request FIFO of DEPTH entries (power of two, >= 2).
//   clk, rst : clock, synchronous active-high reset (flushes pointers/count)
//   push_i   : push request; accepted only when not full (no bypass when full)
//   din_i    : data to push
//   pop_i    : pop request; honoured only when not empty
//   dout_o   : head entry (valid when empty_o == 0)
//   ready_o  : count < DEPTH
//   count_o  : current occupancy
//   empty_o  : count == 0
// ---------------------------------------------------------------------------
module sr_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     din_i,
    input  logic                     pop_i,
    output logic                     dout_o,
    output logic                     ready_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign ready_o = (count_q < CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push    = push_i && ready_o;
    assign pop     = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// sr_cmd_gen
// Turns a stream of desired Q values into legal s/r pulses for an external
// SR flip-flop, then reads back its q and flags any disagreement.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req         : request stream (sr_cmd_gen_if.slave: req_valid/req_ready/req_bit)
//   s, r        : registered set/reset commands to the SR FF (never both high)
//   q_fb        : q fed back from the SR FF
//   q_model     : Q value the block expects the FF to hold
//   busy        : FIFO non-empty or FSM not idle
//   mismatch    : one-cycle pulse during CHECK when q_fb != q_model
//   err_cnt     : saturating mismatch counter
//   fifo_count  : request FIFO occupancy
//   set_cnt, clr_cnt, hold_cnt : saturating per-command counters
//                 (present only when SR_CMD_GEN_STATS_EN is defined)
//
// Command sequence per request: IDLE (pop) -> DRIVE (1 cycle, s/r visible)
// -> SETTLE (SETTLE cycles) -> CHECK (1 cycle) -> IDLE.
// ---------------------------------------------------------------------------
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sr_cmd_gen_if.slave            req,
    output logic                   s,
    output logic                   r,
    input  logic                   q_fb,
    output logic                   q_model,
    output logic                   busy,
    output logic                   mismatch,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef SR_CMD_GEN_STATS_EN
    ,
    output logic [CNT_W-1:0]       set_cnt,
    output logic [CNT_W-1:0]       clr_cnt,
    output logic [CNT_W-1:0]       hold_cnt
`endif
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state_q, state_d;
    logic             tgt_q, tgt_d;
    logic             q_model_q, q_model_d;
    logic             init_q, init_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic             s_q, s_d, r_q, r_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             pop, head, fifo_empty;
    cmd_t             cmd;

    sr_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req.req_valid),
        .din_i   (req.req_bit),
        .pop_i   (pop),
        .dout_o  (head),
        .ready_o (req.req_ready),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        q_model_d    = q_model_q;
        init_d       = init_q;
        settle_cnt_d = settle_cnt_q;
        err_d        = err_q;
        s_d          = 1'b0;
        r_d          = 1'b0;
        pop          = 1'b0;
        mismatch     = 1'b0;
        cmd          = CMD_HOLD;

        case (state_q)
            ST_IDLE: begin
                // The command is computed while popping so that the
                // registered s/r are already high throughout DRIVE.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tgt_d      = head;
                    cmd        = excite(head, q_model_q, init_q);
                    {s_d, r_d} = cmd;
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                q_model_d    = tgt_q;
                init_d       = 1'b0;
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            ST_CHECK: begin
                if (q_fb != q_model_q) begin
                    mismatch = 1'b1;
                    err_d    = sat_inc(err_q);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            q_model_q    <= 1'b0;
            init_q       <= 1'b1;
            settle_cnt_q <= '0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            q_model_q    <= q_model_d;
            init_q       <= init_d;
            settle_cnt_q <= settle_cnt_d;
            s_q          <= s_d;
            r_q          <= r_d;
            err_q        <= err_d;
        end
    end

    // Target is only consumed after being loaded in IDLE; no reset needed.
    always_ff @(posedge clk) begin
        tgt_q <= tgt_d;
    end

    assign s       = s_q;
    assign r       = r_q;
    assign q_model = q_model_q;
    assign err_cnt = err_q;
    assign busy    = (state_q != ST_IDLE) || (fifo_count != '0);

`ifdef SR_CMD_GEN_STATS_EN
    logic [CNT_W-1:0] set_q, clr_q, hold_q;

    // s_q/r_q hold the issued command for exactly the DRIVE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_q  <= '0;
            clr_q  <= '0;
            hold_q <= '0;
        end else if (state_q == ST_DRIVE) begin
            case ({s_q, r_q})
                CMD_SET: set_q  <= sat_inc(set_q);
                CMD_CLR: clr_q  <= sat_inc(clr_q);
                default: hold_q <= sat_inc(hold_q);
            endcase
        end
    end

    assign set_cnt  = set_q;
    assign clr_cnt  = clr_q;
    assign hold_cnt = hold_q;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// ---------------------------------------------------------------------------
// tb_sr_cmd_gen
// Drives sr_cmd_gen with directed and random request streams against a
// behavioural SR flip-flop. Expected commands and check outcomes are queued
// when a request is accepted; a monitor pops them as the DUT issues commands.
// ---------------------------------------------------------------------------
module tb_sr_cmd_gen;
    import sr_cmd_pkg::*;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;
    localparam int CNT_W  = 2;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sr_cmd_gen_if req_if();

    logic                   s, r, q_fb, q_model, busy, mismatch;
    logic [CNT_W-1:0]       err_cnt;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef SR_CMD_GEN_STATS_EN
    logic [CNT_W-1:0]       set_cnt, clr_cnt, hold_cnt;
`endif

    sr_cmd_gen #(
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req_if),
        .s          (s),
        .r          (r),
        .q_fb       (q_fb),
        .q_model    (q_model),
        .busy       (busy),
        .mismatch   (mismatch),
        .err_cnt    (err_cnt),
        .fifo_count (fifo_count)
`ifdef SR_CMD_GEN_STATS_EN
        ,
        .set_cnt    (set_cnt),
        .clr_cnt    (clr_cnt),
        .hold_cnt   (hold_cnt)
`endif
    );

    // Behavioural SR flip-flop; power-up value deliberately 1.
    logic ff_q  = 1'b1;
    logic stuck = 1'b0;
    always @(posedge clk) begin
        if (s && !r)      ff_q <= 1'b1;
        else if (r && !s) ff_q <= 1'b0;
    end
    assign q_fb = stuck ? 1'b0 : ff_q;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic             mis;
        logic             qm;
        logic [CNT_W-1:0] err;
    } chk_t;

    logic [1:0] cmd_q[$];
    chk_t       chk_q[$];

    // Reference model state: what the FF should hold, whether the FF is still
    // in an unknown state, and the expected error count.
    logic mq    = 1'b0;
    logic minit = 1'b1;
    int   merr  = 0;
    int   full_seen = 0;

    task automatic model_accept(input logic b);
        logic [1:0] c;
        logic       mis;
        chk_t       e;
        if (minit || (b != mq)) c = b ? 2'b10 : 2'b01;
        else                    c = 2'b00;
        mq    = b;
        minit = 1'b0;
        mis   = stuck && b;
        if (mis && merr < ERR_MAX) merr++;
        e.mis = mis;
        e.qm  = b;
        e.err = CNT_W'(merr);
        cmd_q.push_back(c);
        chk_q.push_back(e);
    endtask

    task automatic send(input logic b);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            @(negedge clk);
            req_if.req_valid = 1'b1;
            req_if.req_bit   = b;
            acc = req_if.req_ready;
            @(posedge clk);
            tries++;
        end
        if (acc) model_accept(b);
        else check("send_timeout", 0, 1);
    endtask

    task automatic stop_valid();
        @(negedge clk);
        req_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset(input bit chk);
        @(negedge clk);
        rst = 1'b1;
        req_if.req_valid = 1'b0;
        mq    = 1'b0;
        minit = 1'b1;
        merr  = 0;
        @(negedge clk);
        if (chk) begin
            check("rst_s",          int'(s),                0);
            check("rst_r",          int'(r),                0);
            check("rst_mismatch",   int'(mismatch),         0);
            check("rst_err_cnt",    int'(err_cnt),          0);
            check("rst_q_model",    int'(q_model),          0);
            check("rst_fifo_count", int'(fifo_count),       0);
            check("rst_busy",       int'(busy),             0);
            check("rst_req_ready",  int'(req_if.req_ready), 1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops expectations when the DUT issues a command or checks.
    initial begin : monitor
        logic             pend;
        logic [CNT_W-1:0] pend_err;
        logic [1:0]       ec;
        chk_t             ce;
        pend     = 1'b0;
        pend_err = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cmd_q.delete();
                chk_q.delete();
                pend = 1'b0;
            end else begin
                if (s && r) check("s_and_r", 1, 0);
                check("req_ready", int'(req_if.req_ready), int'(fifo_count < DEPTH));
                if (fifo_count == DEPTH) full_seen++;
                if (pend) begin
                    check("err_cnt", int'(err_cnt), int'(pend_err));
                    pend = 1'b0;
                end
                if (dut.state_q == ST_DRIVE) begin
                    if (cmd_q.size() == 0) begin
                        check("unexpected_cmd", int'({s, r}), -1);
                    end else begin
                        ec = cmd_q.pop_front();
                        check("cmd_sr", int'({s, r}), int'(ec));
                    end
                end else if (s || r) begin
                    check("sr_outside_drive", int'({s, r}), 0);
                end
                if (dut.state_q == ST_CHECK) begin
                    if (chk_q.size() == 0) begin
                        check("unexpected_check", 1, 0);
                    end else begin
                        ce = chk_q.pop_front();
                        check("mismatch", int'(mismatch), int'(ce.mis));
                        check("q_model",  int'(q_model),  int'(ce.qm));
                        pend     = 1'b1;
                        pend_err = ce.err;
                    end
                end else if (mismatch) begin
                    check("mismatch_outside_check", 1, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int seen_before;
        int n;
        req_if.req_valid = 1'b0;
        req_if.req_bit   = 1'b0;

        // Reset state, then first request 0 must be driven as CLR.
        do_reset(1'b1);
        send(1'b0);
        stop_valid();
        wait_idle();
        check("t2_q_model", int'(q_model), 0);
        check("t2_err_cnt", int'(err_cnt), 0);

        // SET, HOLD, CLR, HOLD, SET with a working flip-flop.
        do_reset(1'b1);
        send(1'b1); send(1'b1); send(1'b0); send(1'b0); send(1'b1);
        stop_valid();
        wait_idle();
        check("t1_err_cnt", int'(err_cnt), 0);
        check("t1_q_model", int'(q_model), 1);
`ifdef SR_CMD_GEN_STATS_EN
        check("t1_set_cnt",  int'(set_cnt),  2);
        check("t1_clr_cnt",  int'(clr_cnt),  1);
        check("t1_hold_cnt", int'(hold_cnt), 2);
`endif

        // Back-to-back burst fills the FIFO; nothing lost, order kept.
        seen_before = full_seen;
        send(1'b1); send(1'b0); send(1'b1); send(1'b1); send(1'b0); send(1'b1);
        stop_valid();
        wait_idle();
        check("t3_fifo_reached_full", int'(full_seen > seen_before), 1);
        check("t3_err_cnt", int'(err_cnt), 0);

        // q_fb stuck at 0: every request for 1 fails; counter saturates.
        stuck = 1'b1;
        send(1'b1);
        stop_valid();
        wait_idle();
        check("t4_err_one", int'(err_cnt), 1);
        send(1'b1); send(1'b1); send(1'b1); send(1'b1);
        stop_valid();
        wait_idle();
        check("t4_err_sat", int'(err_cnt), ERR_MAX);
        stuck = 1'b0;

        // Reset during SETTLE with three requests still queued.
        send(1'b1); send(1'b0); send(1'b1); send(1'b0); send(1'b1);
        stop_valid();
        n = 0;
        while (!(dut.state_q == ST_SETTLE && fifo_count == 3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_settle_with_3", int'(dut.state_q == ST_SETTLE && fifo_count == 3), 1);
        rst   = 1'b1;
        mq    = 1'b0;
        minit = 1'b1;
        merr  = 0;
        @(negedge clk);
        check("t5_s",          int'(s),          0);
        check("t5_r",          int'(r),          0);
        check("t5_fifo_count", int'(fifo_count), 0);
        check("t5_busy",       int'(busy),       0);
        check("t5_err_cnt",    int'(err_cnt),    0);
        @(negedge clk);
        rst = 1'b0;

        // Random stream with occasional gaps and stuck-feedback phases.
        for (int i = 0; i < 60; i++) begin
            if (i % 12 == 0) begin
                stop_valid();
                wait_idle();
                stuck = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) begin
                stop_valid();
                repeat ($urandom_range(1, 6)) @(negedge clk);
            end
            send(1'($urandom_range(0, 1)));
        end
        stop_valid();
        wait_idle();
        stuck = 1'b0;
        check("rand_err_cnt",   int'(err_cnt),     merr);
        check("rand_q_model",   int'(q_model),     int'(mq));
        check("cmd_queue_left", cmd_q.size(),      0);
        check("chk_queue_left", chk_q.size(),      0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_cmd_gen.md
Name: sr_cmd_gen

Overview:
Command-side counterpart to the clocked SR flip-flop: turns a stream of desired Q values into legal s/r pulses using the excitation table, the inverse of the FF's characteristic table. It drives an external sr_flipflop, reads back its q, and flags any mismatch. It sits between a controller (valid/ready request stream) and the SR FF under control, and is also used as the self-checking stimulus source in FF regressions.

Parameters:
DEPTH, 4, request FIFO depth; power of two, minimum 2.
SETTLE, 1, wait cycles after the drive cycle before q_fb is sampled; minimum 1.
CNT_W, 8, width of error and statistics counters.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  FIFO can accept a request.
req_bit  in  1  desired Q value.
s  out  1  set command to the SR FF; registered.
r  out  1  reset command to the SR FF; registered.
q_fb  in  1  q fed back from the SR FF.
q_model  out  1  Q value the block expects the FF to hold.
busy  out  1  FIFO non-empty or FSM not in IDLE.
mismatch  out  1  one-cycle pulse when a check fails.
err_cnt  out  CNT_W  saturating mismatch count.
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - s=0, r=0, mismatch=0, err_cnt=0, q_model=0, FIFO flushed, FSM to IDLE, init flag set.
  - req_ready=1 from the first cycle after reset.
  - A reset mid-operation abandons the current command and flushes the FIFO. s/r return to 0 at that edge.
- FIFO:
  - A push occurs when req_valid && req_ready. req_ready = (fifo_count < DEPTH).
  - When full, there is no push even if a pop happens in the same cycle (no bypass).
  - A push and a pop in the same cycle leave the count unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into tgt and go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: exactly 1 cycle. Set s/r from the excitation table (below), set q_model<=tgt, clear init, go to SETTLE.
  - SETTLE: count SETTLE cycles with s=r=0, then go to CHECK.
  - CHECK: 1 cycle. If q_fb != q_model, pulse mismatch and increment err_cnt (holds at 2^CNT_W-1). Go to IDLE.
- Excitation table (s,r), applied during DRIVE:
  - tgt=1, q_model=0 -> (1,0).
  - tgt=0, q_model=1 -> (0,1).
  - tgt == q_model -> (0,0) hold.
  - init=1 overrides the hold case: the first command after reset always drives explicitly, (1,0) or (0,1), so the external FF's unknown power-up state is resolved.
- Invariant: s&r is never 1. s and r are each high for at most one cycle per command.
- Latency: a request accepted at edge N into an empty FIFO with the FSM in IDLE gives the pop at edge N+1 and s/r high in cycle N+1..N+2. The check occurs SETTLE+1 cycles after the drive cycle.
- Throughput: one command per SETTLE+3 cycles.
- busy=1 whenever state!=IDLE or fifo_count!=0.

Optional Feature:
SR_CMD_GEN_STATS_EN:
- Defined: adds outputs set_cnt, clr_cnt, hold_cnt (CNT_W each, saturating, reset to 0). The matching counter increments on each DRIVE cycle according to the command issued.
- Undefined: these ports and registers are absent. All other behaviour is identical.

Decomposition:
Package sr_cmd_pkg holds:
- FSM state enum: ST_IDLE, ST_DRIVE, ST_SETTLE, ST_CHECK.
- Command encoding {s,r}: CMD_HOLD=2'b00, CMD_SET=2'b10, CMD_CLR=2'b01.
- Function excite(tgt,q,init) returning the command.
The FIFO is a natural sub-module, sr_cmd_fifo (DEPTH, 1-bit data, count output, synchronous rst).

Test Plan:
- Reset, then req_bit sequence 1,1,0,0,1 with the DUT wired to sr_flipflop, SETTLE=1 -> s/r pulses SET, HOLD, CLR, HOLD, SET; mismatch never asserted; err_cnt=0.
- First request after reset is req_bit=0 -> (0,1) issued, not HOLD; q_model=0; no mismatch.
- Hold req_valid=1 for 6 requests while the FSM is busy (DEPTH=4) -> req_ready drops when fifo_count=4; no request is lost; commands are issued in order.
- Stick q_fb at 0; request 1 -> mismatch pulses for exactly 1 cycle in CHECK; err_cnt=1. With CNT_W=2, 5 failures leave err_cnt=3 (saturated).
- Assert rst during SETTLE with 3 requests queued -> next cycle s=r=0, fifo_count=0, busy=0, err_cnt=0.
- Every cycle of every test: assertion !(s&&r). With SR_CMD_GEN_STATS_EN, after test 1: set_cnt=2, clr_cnt=1, hold_cnt=2.
